// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined AND/OR/XOR/NOR unit with zero flag and valid/ready handshakes.
// Defining LOGIC_UNIT_PERF_EN adds the saturating output-stall counter port perf_stall_cnt.
module logic_unit_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero
`ifdef LOGIC_UNIT_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt
`endif
);

    logic             advance_s;
    logic [WIDTH-1:0] result_s;
    logic             zero_s;
    logic             valid_r [STAGES];
    logic [WIDTH-1:0] data_r  [STAGES];
    logic             zero_r  [STAGES];

    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return ~|v;
    endfunction

    // Operation select at the pipe input; the zero flag travels with its result.
    always_comb begin
        result_s = {WIDTH{1'b0}};
        case (in_op)
            2'b00:   result_s = in_a & in_b;
            2'b01:   result_s = in_a | in_b;
            2'b10:   result_s = in_a ^ in_b;
            2'b11:   result_s = ~(in_a | in_b);
            default: result_s = {WIDTH{1'b0}};
        endcase
        zero_s = is_zero(result_s);
    end

    // A stall freezes every stage, bubbles included, so beats never reorder or merge.
    assign advance_s = !valid_r[STAGES-1] || out_ready;
    assign in_ready  = advance_s;

    // Pipeline registers: shift by one stage on advance, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_r[i] <= 1'b0;
                data_r[i]  <= {WIDTH{1'b0}};
                zero_r[i]  <= 1'b0;
            end
        end else if (advance_s) begin
            valid_r[0] <= in_valid;
            data_r[0]  <= result_s;
            zero_r[0]  <= zero_s;
            for (int i = 1; i < STAGES; i++) begin
                valid_r[i] <= valid_r[i-1];
                data_r[i]  <= data_r[i-1];
                zero_r[i]  <= zero_r[i-1];
            end
        end
    end

    assign out_valid  = valid_r[STAGES-1];
    assign out_result = data_r[STAGES-1];
    assign out_zero   = zero_r[STAGES-1];

`ifdef LOGIC_UNIT_PERF_EN
    // Count cycles where a finished beat waits on downstream; saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= 32'h0000_0000;
        end else if (valid_r[STAGES-1] && !out_ready && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 32'h0000_0001;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: randomized and directed beats checked against a
// per-bit truth-table model; small WIDTH=8 instances cover STAGES=1 and STAGES=4 latency.
module tb_logic_unit_pipe;
    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic [1:0]  in_op = 2'd0;
    logic        in_ready, out_valid, out_zero;
    logic [31:0] out_result;

    logic        v8 = 1'b0;
    logic [7:0]  a8 = 8'd0;
    logic [7:0]  b8 = 8'd0;
    logic [1:0]  op8 = 2'd0;
    logic        rdy1, val1, zero1, rdy4, val4, zero4;
    logic [7:0]  res1, res4;

`ifdef LOGIC_UNIT_PERF_EN
    logic [31:0] perf_cnt, perf1, perf4;
`endif

    int checks = 0;
    int passed = 0;
    logic [32:0] exp_q[$];
    logic [32:0] out_log[$];
    logic [32:0] e;
    int cyc = 0, last_xfer = -10, streak = 0;
    logic prev_stall = 1'b0;
    logic [31:0] held_res = 32'd0;
    logic held_zero = 1'b0;
    logic [31:0] op_exp [4] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000};
    int base, lat, bp_n, mid_cnt, lat1, lat4;
    logic [7:0] r1, r4;
    logic z1, z4;
    bit rnd_done;

    logic_unit_pipe #(.WIDTH(32), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_zero(out_zero)
`ifdef LOGIC_UNIT_PERF_EN
        , .perf_stall_cnt(perf_cnt)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy1),
        .in_a(a8), .in_b(b8), .in_op(op8), .out_valid(val1),
        .out_ready(1'b1), .out_result(res1), .out_zero(zero1)
`ifdef LOGIC_UNIT_PERF_EN
        , .perf_stall_cnt(perf1)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(rdy4),
        .in_a(a8), .in_b(b8), .in_op(op8), .out_valid(val4),
        .out_ready(1'b1), .out_result(res4), .out_zero(zero4)
`ifdef LOGIC_UNIT_PERF_EN
        , .perf_stall_cnt(perf4)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: each result bit is a 2-input truth-table lookup on (a[i], b[i]).
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op);
        logic [3:0]  tt;
        logic [31:0] r;
        case (op)
            2'b00:   tt = 4'b1000;
            2'b01:   tt = 4'b1110;
            2'b10:   tt = 4'b0110;
            default: tt = 4'b0001;
        endcase
        for (int i = 0; i < 32; i++) r[i] = tt[{a[i], b[i]}];
        return {(r == 32'd0), r};
    endfunction

    // Input side of the scoreboard: record every accepted beat.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_op));
    end

    always @(negedge rst_n) exp_q.delete();

    // Output side: pop on every transfer; a stalled beat must stay put.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_stall) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_result", out_result, held_res);
                chk("hold_zero", 32'(out_zero), 32'(held_zero));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_beat: got %h expected no beat", out_result);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", out_result, e[31:0]);
                    chk("zero", 32'(out_zero), 32'(e[32]));
                end
                out_log.push_back({out_zero, out_result});
                streak = (last_xfer == cyc - 1) ? streak + 1 : 1;
                last_xfer = cyc;
            end
            prev_stall = out_valid && !out_ready;
            held_res   = out_result;
            held_zero  = out_zero;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        bit acc;
        int n;
        n = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        do begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end while (!acc && n < 500);
        if (!acc) begin
            checks++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 500 cycles");
        end
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom; in_op = 2'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        // Reset with random inputs toggling.
        repeat (3) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom); in_a = $urandom; in_b = $urandom; in_op = 2'($urandom);
            @(negedge clk);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_result", out_result, 32'd0);
            chk("rst_out_zero", 32'(out_zero), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end
`ifdef LOGIC_UNIT_PERF_EN
        chk("rst_perf", perf_cnt, 32'd0);
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b1;

        // First-beat latency.
        send(32'h1234_5678, 32'h0F0F_0F0F, 2'b10);
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        chk("first_latency", lat, S);
        drain();

        // All four operations back-to-back.
        base = out_log.size();
        for (int k = 0; k < 4; k++) send(32'hF0F0_00FF, 32'h0FF0_0F0F, 2'(k));
        drain();
        for (int k = 0; k < 4; k++) begin
            chk("op_result", out_log[base+k][31:0], op_exp[k]);
            chk("op_zero", 32'(out_log[base+k][32]), 32'd0);
        end
        chk("op_consecutive", streak, 32'd4);

        // Zero flag via AND and NOR.
        base = out_log.size();
        send(32'hAAAA_AAAA, 32'h5555_5555, 2'b00);
        send(32'hAAAA_AAAA, 32'h5555_5555, 2'b11);
        drain();
        for (int k = 0; k < 2; k++) begin
            chk("zf_result", out_log[base+k][31:0], 32'd0);
            chk("zf_zero", 32'(out_log[base+k][32]), 32'd1);
        end

        // Back-pressure: five stalled cycles once the first beat is presented.
        base = out_log.size();
        fork
            begin
                for (int k = 1; k <= 6; k++) send(32'(k), 32'd0, 2'b01);
            end
            begin
                bp_n = 0;
                while (!out_valid && bp_n < 100) begin @(posedge clk); #1; bp_n++; end
                chk("bp_valid_rise", 32'(out_valid), 32'd1);
                out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_in_ready", 32'(in_ready), 32'd0);
                    chk("bp_held_result", out_result, 32'd1);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_count", out_log.size() - base, 32'd6);
        for (int k = 0; k < 6; k++) chk("bp_order", out_log[base+k][31:0], 32'(k + 1));
`ifdef LOGIC_UNIT_PERF_EN
        chk("bp_perf", perf_cnt, 32'd5);
`endif

        // Random beats with random gaps and random back-pressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    send($urandom, $urandom, 2'($urandom));
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Asynchronous reset with two beats in flight.
        send(32'h0000_0011, 32'h0000_0022, 2'b00);
        send(32'h0000_0033, 32'h0000_0044, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_flush", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        mid_cnt = 0;
        repeat (10) begin @(negedge clk); if (out_valid) mid_cnt++; end
        chk("no_stale_beat", mid_cnt, 32'd0);

        // WIDTH=8 latency for STAGES=1 and STAGES=4.
        @(posedge clk); #1;
        chk("w8_ready", 32'(rdy1 && rdy4), 32'd1);
        v8 = 1'b1; a8 = 8'h3C; b8 = 8'hC3; op8 = 2'b10;
        @(posedge clk); #1;
        v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        lat1 = 0; lat4 = 0; r1 = 8'd0; r4 = 8'd0; z1 = 1'b1; z4 = 1'b1;
        for (int l = 1; l <= 8; l++) begin
            if (val1 && lat1 == 0) begin lat1 = l; r1 = res1; z1 = zero1; end
            if (val4 && lat4 == 0) begin lat4 = l; r4 = res4; z4 = zero4; end
            @(posedge clk); #1;
        end
        chk("s1_latency", lat1, 32'd1);
        chk("s4_latency", lat4, 32'd4);
        chk("s1_result", 32'(r1), 32'h0000_00FF);
        chk("s4_result", 32'(r4), 32'h0000_00FF);
        chk("s1_zero", 32'(z1), 32'd0);
        chk("s4_zero", 32'(z4), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, pipelined bitwise logic unit for the MIPS_32 ALU path; the successor to the single-bit 2-input AND gate.
- Performs AND/OR/XOR/NOR on WIDTH-bit operands and produces a zero flag.
- Sits between the decode/operand-fetch stage and the execute result mux, with valid/ready handshakes on both sides.
- Latency is configurable; back-pressure from downstream stalls the whole pipe.

Parameters:
- WIDTH, 32, operand and result width in bits (>=1).
- STAGES, 2, pipeline register depth and latency in cycles (1..4).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  unit accepts a beat this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- out_result  output  WIDTH  operation result.
- out_zero  output  1  1 when out_result == 0.
- perf_stall_cnt  output  32  present only with LOGIC_UNIT_PERF_EN; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset: while rst_n=0, every stage valid bit is 0 and every stage data/zero register is 0. So out_valid=0, out_result=0, out_zero=0, and perf_stall_cnt=0. in_ready=1 immediately after reset release.
- Compute: result = op-selected bitwise function of in_a/in_b, evaluated combinationally at the pipe input. NOR = ~(a|b), full WIDTH bits. The zero flag is computed alongside the result (reduction NOR of the result) and carried with it.
- Pipe structure: STAGES registers, each holding {valid, result, zero}. out_* are driven directly from the last stage, with no combinational path from in_* to out_*.
- Advance rule: advance = !valid[STAGES-1] | out_ready, and in_ready = advance.
- On advance: every stage loads from the previous stage. Stage 0 loads {in_valid, result, zero}.
- On no advance: all stages hold.
- Bubbles: bubbles are not collapsed. A stall holds empty stages too.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_a/in_b/in_op are sampled only on transfer. Input values in other cycles are don't-care.
  - While out_valid=1 and out_ready=0, out_result/out_zero hold stable.
- Latency and throughput: a beat accepted in cycle N appears with out_valid=1 in cycle N+STAGES if no stall occurs. Sustained throughput is 1 beat/cycle with out_ready held high.
- Simultaneous events: with the pipe full and out_ready=1, in the same cycle:
  - the last stage's beat is consumed;
  - a new beat is accepted;
  - all middle stages shift.
  No beat is lost or duplicated.
- Ordering: results leave in acceptance order.
- Reset mid-operation: all in-flight beats are discarded and nothing is emitted afterwards. An upstream beat presented in the reset-release cycle is accepted normally.
- Width: no carries and no sign handling. Bit i of the result depends only on bit i of in_a and in_b.

Optional Feature:
- Macro: LOGIC_UNIT_PERF_EN.
- Defined:
  - Port perf_stall_cnt exists.
  - The counter increments by 1 every cycle with valid[STAGES-1]=1 and out_ready=0.
  - It saturates at 32'hFFFF_FFFF and clears on rst_n=0.
- Not defined: the port and counter are absent, and the functional behaviour is otherwise identical.

Test Plan (WIDTH=32, STAGES=2 unless stated):
- Reset check: hold rst_n=0 with random inputs -> out_valid=0, out_result=0, in_ready=1. Release rst_n -> first accepted beat emerges exactly 2 cycles later.
- Op coverage: a=32'hF0F0_00FF, b=32'h0FF0_0F0F, op 00/01/10/11 back-to-back, out_ready=1 -> results 32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0, 32'h000F_F000 on 4 consecutive cycles. out_zero=0 on all four.
- Zero flag: a=32'hAAAA_AAAA, b=32'h5555_5555, op=AND -> out_result=0, out_zero=1. Same operands with op=NOR -> out_result=0, out_zero=1.
- Back-pressure:
  - Stimulus: stream beats 1..6 (a=k, b=0, op=OR); hold out_ready=0 for 5 cycles once out_valid rises, then release.
  - Response: in_ready=0 throughout the stall, out_result held at 1, then results 1..6 in order with no loss or duplication.
  - With LOGIC_UNIT_PERF_EN defined: perf_stall_cnt=5.
- Reset mid-stream: assert rst_n=0 asynchronously, mid-cycle, with 2 beats in flight -> out_valid drops without waiting for a clock edge. No stale beat appears after release.
- STAGES=1 and STAGES=4, WIDTH=8: a=8'h3C, b=8'hC3, op=XOR -> 8'hFF appears 1 and 4 cycles after acceptance respectively.
